// File: rtl/spwtcr_pkg.sv
// spwtcr_pkg: SpaceWire TX character types, control codes and the character builder.
package spwtcr_pkg;

    typedef enum logic [2:0] {
        CHAR_DATA = 3'd0,
        CHAR_FCT  = 3'd1,
        CHAR_EOP  = 3'd2,
        CHAR_EEP  = 3'd3,
        CHAR_TIME = 3'd4
    } tx_char_t;

    localparam logic [1:0] CTRL_FCT = 2'b00;
    localparam logic [1:0] CTRL_EOP = 2'b01;
    localparam logic [1:0] CTRL_EEP = 2'b10;
    localparam logic [1:0] CTRL_ESC = 2'b11;

    localparam int CHAR_BITS = 14;
    localparam logic [3:0] LEN_CTRL = 4'd4;
    localparam logic [3:0] LEN_NULL = 4'd8;
    localparam logic [3:0] LEN_DATA = 4'd10;
    localparam logic [3:0] LEN_TIME = 4'd14;

    // bits[0] is transmitted first; hist is the XOR of the last sub-character's payload
    typedef struct packed {
        logic [CHAR_BITS-1:0] bits;
        logic [3:0]           len;
        logic                 hist;
    } tx_word_t;

    // control parity = 1 ^ hist ^ flag(1) = hist
    function automatic logic [3:0] ctrl_char(input logic h, input logic [1:0] c);
        return {c[0], c[1], 1'b1, h};
    endfunction

    function automatic tx_word_t build_char(input logic valid, input tx_char_t t,
                                            input logic [7:0] d, input logic h);
        tx_word_t w;
        logic [3:0] esc;
        esc = ctrl_char(h, CTRL_ESC);
        w = '{{6'd0, ctrl_char(^CTRL_ESC, CTRL_FCT), esc}, LEN_NULL, ^CTRL_FCT};
        if (valid) begin
            case (t)
                CHAR_DATA: w = '{{4'd0, d, 1'b0, ~h}, LEN_DATA, ^d};
                CHAR_FCT:  w = '{{10'd0, ctrl_char(h, CTRL_FCT)}, LEN_CTRL, ^CTRL_FCT};
                CHAR_EOP:  w = '{{10'd0, ctrl_char(h, CTRL_EOP)}, LEN_CTRL, ^CTRL_EOP};
                CHAR_EEP:  w = '{{10'd0, ctrl_char(h, CTRL_EEP)}, LEN_CTRL, ^CTRL_EEP};
                CHAR_TIME: w = '{{d, 1'b0, ~(^CTRL_ESC), esc}, LEN_TIME, ^d};
                default:   w = w;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/spwtcr_tx_ds_out.sv
// spwtcr_tx_ds_out: bit-period divider and Data/Strobe line encoding.
module spwtcr_tx_ds_out #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 bit_strobe,
    input  logic                 bit_in,
    output logic                 Dout,
    output logic                 Sout,
    output logic                 bit_last
);

    logic [DIV_WIDTH-1:0] cnt;

    assign bit_last = cnt == '0;

    // strobe flips only when data repeats, so exactly one line changes per bit
    always_ff @(posedge CLOCK) begin
        if (RESET || !enable) begin
            Dout <= 1'b0;
            Sout <= 1'b0;
            cnt  <= '0;
        end else if (bit_strobe) begin
            Dout <= bit_in;
            Sout <= Sout ^ (bit_in == Dout);
            cnt  <= div;
        end else if (!bit_last) begin
            cnt  <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spwtcr_tx_ds_encoder.sv
// spwtcr_tx_ds_encoder: SpaceWire TX character encoder and D/S serializer.
// Optional SPWTCR_TX_STATS_EN adds NULL/DATA load counters with stats_clr.
module spwtcr_tx_ds_encoder
    import spwtcr_pkg::*;
#(
    parameter int DIV_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 14
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] tx_div,
    input  logic                 char_valid,
    input  tx_char_t             char_type,
    input  logic [7:0]           char_data,
    output logic                 char_ready,
    output logic                 Dout,
    output logic                 Sout,
    output logic                 busy
`ifdef SPWTCR_TX_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [15:0]          null_count,
    output logic [15:0]          data_count
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state, nxt;
    logic [SHIFT_WIDTH-1:0] shreg;
    logic [3:0]             rem;
    logic                   hist;
    logic [DIV_WIDTH-1:0]   div_q;
    logic                   bit_last, last, advance, take, bit_strobe, bit_in;
    tx_word_t               c;

    // char_ready doubles as the load strobe: NULL is loaded when nothing is offered
    always_comb begin
        last       = state == SHIFT && bit_last && rem == 4'd0;
        advance    = state == SHIFT && bit_last && rem != 4'd0;
        char_ready = enable && !RESET && (state == LOAD || last);
        busy       = enable && !RESET && state == SHIFT;
        take       = char_valid && char_ready;
        c          = build_char(take, char_type, char_data, hist);
        bit_strobe = char_ready || advance;
        bit_in     = char_ready ? c.bits[0] : shreg[0];
        nxt        = !enable ? IDLE : state == IDLE ? LOAD : SHIFT;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || !enable) begin
            state <= IDLE;
            shreg <= '0;
            rem   <= '0;
            hist  <= 1'b0;
            div_q <= '0;
        end else begin
            state <= nxt;
            if (char_ready) begin
                shreg <= SHIFT_WIDTH'(c.bits >> 1);
                rem   <= c.len - 4'd1;
                hist  <= c.hist;
                div_q <= tx_div;
            end else if (advance) begin
                shreg <= shreg >> 1;
                rem   <= rem - 4'd1;
            end
        end
    end

    spwtcr_tx_ds_out #(.DIV_WIDTH(DIV_WIDTH)) u_out (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .enable     (enable),
        .div        (char_ready ? tx_div : div_q),
        .bit_strobe (bit_strobe),
        .bit_in     (bit_in),
        .Dout       (Dout),
        .Sout       (Sout),
        .bit_last   (bit_last)
    );

`ifdef SPWTCR_TX_STATS_EN
    always_ff @(posedge CLOCK) begin
        if (RESET || stats_clr) begin
            null_count <= '0;
            data_count <= '0;
        end else begin
            if (char_ready && !(take && char_type <= CHAR_TIME))
                null_count <= null_count + 16'd1;
            if (take && char_type == CHAR_DATA)
                data_count <= data_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spwtcr_tx_ds_encoder.sv
// tb_spwtcr_tx_ds_encoder: randomized bench against a bit-stream reference model.
module tb_spwtcr_tx_ds_encoder;
    import spwtcr_pkg::*;

    logic       CLOCK = 1'b0, RESET = 1'b1, enable = 1'b0, char_valid = 1'b0;
    logic [7:0] tx_div = 8'd0, char_data = 8'd0;
    tx_char_t   char_type = CHAR_DATA;
    logic       char_ready, Dout, Sout, busy;
`ifdef SPWTCR_TX_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] null_count, data_count;
`endif

    always #5 CLOCK = ~CLOCK;

    spwtcr_tx_ds_encoder dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .enable     (enable),
        .tx_div     (tx_div),
        .char_valid (char_valid),
        .char_type  (char_type),
        .char_data  (char_data),
        .char_ready (char_ready),
        .Dout       (Dout),
        .Sout       (Sout),
        .busy       (busy)
`ifdef SPWTCR_TX_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .null_count (null_count),
        .data_count (data_count)
`endif
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: per-cycle queue of expected {D,S}; phase 0 idle, 1 load, 2 shifting
    typedef struct { tx_char_t t; logic [7:0] d; } offer_t;
    offer_t     offers[$];
    logic [1:0] q[$];
    logic       cb[$];
    int         phase = 0;
    logic       pd = 1'b0, ps = 1'b0, hist_m = 1'b0;

    // one sub-character: parity, flag, payload (pay[0] sent first)
    task automatic sub(input logic flag, input logic [7:0] pay, input int n);
        logic x;
        x = 1'b0;
        cb.push_back(1'b1 ^ hist_m ^ flag);
        cb.push_back(flag);
        for (int i = 0; i < n; i++) begin
            cb.push_back(pay[i]);
            x ^= pay[i];
        end
        hist_m = x;
    endtask

    task automatic enqueue(input logic valid, input tx_char_t t, input logic [7:0] d, input int div);
        logic s;
        cb.delete();
        if (!valid || t > CHAR_TIME) begin
            sub(1'b1, 8'b11, 2);
            sub(1'b1, 8'b00, 2);
        end else begin
            case (t)
                CHAR_DATA: sub(1'b0, d, 8);
                CHAR_FCT:  sub(1'b1, 8'b00, 2);
                CHAR_EOP:  sub(1'b1, 8'b10, 2);
                CHAR_EEP:  sub(1'b1, 8'b01, 2);
                default: begin
                    sub(1'b1, 8'b11, 2);
                    sub(1'b0, d, 8);
                end
            endcase
        end
        foreach (cb[i]) begin
            s  = (cb[i] == pd) ? ~ps : ps;
            pd = cb[i];
            ps = s;
            repeat (div + 1) q.push_back({cb[i], s});
        end
    endtask

    function automatic logic exp_ready();
        return enable && !RESET && (phase == 1 || (phase == 2 && q.size() == 1));
    endfunction

    task automatic model_edge();
        logic rdy;
        rdy = exp_ready();
        if (RESET || !enable) begin
            phase = 0;
            q.delete();
            pd = 1'b0;
            ps = 1'b0;
            hist_m = 1'b0;
        end else if (phase == 0) begin
            phase = 1;
        end else begin
            if (phase == 2 && q.size() > 0) void'(q.pop_front());
            if (rdy) begin
                enqueue(char_valid, char_type, char_data, int'(tx_div));
                if (char_valid && offers.size() > 0) void'(offers.pop_front());
                phase = 2;
            end
        end
    endtask

    logic       capturing = 1'b0;
    int         ncap = 0;
    logic [7:0] capd, caps;

    task tick();
        logic [1:0] e;
        @(posedge CLOCK);
        model_edge();
        @(negedge CLOCK);
        e = (phase == 2 && q.size() > 0) ? q[0] : 2'b00;
        check("dout", 32'(Dout), 32'(e[1]));
        check("sout", 32'(Sout), 32'(e[0]));
        check("char_ready", 32'(char_ready), 32'(exp_ready()));
        check("busy", 32'(busy), 32'(enable && !RESET && phase == 2));
        if (capturing && phase == 2 && ncap < 8) begin
            capd[ncap] = Dout;
            caps[ncap] = Sout;
            ncap++;
        end
    endtask

    task drive(input logic gate);
        char_valid = gate && offers.size() > 0;
        if (offers.size() > 0) begin
            char_type = offers[0].t;
            char_data = offers[0].d;
        end
    endtask

    task run_until_empty(input int budget);
        for (int i = 0; i < budget && offers.size() > 0; i++) begin
            drive(1'b1);
            tick();
        end
        if (offers.size() > 0) check("offer_timeout", 32'(offers.size()), 32'd0);
        drive(1'b0);
    endtask

    task push(input tx_char_t t, input logic [7:0] d);
        offers.push_back('{t, d});
    endtask

    initial begin
        @(negedge CLOCK);
        repeat (3) tick();
        check("rst_dout", 32'(Dout), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd0);
        RESET = 1'b0;
        repeat (2) tick();

        enable = 1'b1;
        capturing = 1'b1;
        ncap = 0;
        repeat (30) tick();
        check("null_dout_seq", 32'(capd), 32'h2E);
        check("null_sout_seq", 32'(caps), 32'h7B);

        push(CHAR_DATA, 8'h00);
        push(CHAR_DATA, 8'h01);
        run_until_empty(100);
        repeat (30) tick();

        tx_div = 8'd3;
        push(CHAR_DATA, 8'hA5);
        run_until_empty(200);
        repeat (6) tick();
        tx_div = 8'd1;
        repeat (80) tick();

        tx_div = 8'd0;
        push(CHAR_TIME, 8'h2A);
        push(CHAR_EOP, 8'h00);
        run_until_empty(100);
        repeat (30) tick();

        push(CHAR_DATA, 8'h3C);
        run_until_empty(100);
        repeat (4) tick();
        enable = 1'b0;
        tick();
        check("disable_dout", 32'(Dout), 32'd0);
        enable = 1'b1;
        ncap = 0;
        repeat (20) tick();
        check("reenable_esc_parity", 32'(capd[0]), 32'd0);
        capturing = 1'b0;

        for (int i = 0; i < 80; i++) push(tx_char_t'($urandom_range(0, 7)), 8'($urandom));
        for (int cyc = 0; cyc < 20000 && offers.size() > 0; cyc++) begin
            if ($urandom_range(0, 19) == 0) tx_div = 8'($urandom_range(0, 3));
            enable = $urandom_range(0, 299) != 0;
            drive($urandom_range(0, 3) != 0);
            tick();
        end
        if (offers.size() > 0) check("random_timeout", 32'(offers.size()), 32'd0);
        enable = 1'b1;
        drive(1'b0);
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
